mem_access_unit: RTL
====================

# mem_access_unit

MEM-stage load/store datapath sitting between the EX/MEM pipeline register and the data memory. It narrows 32-bit store data onto byte lanes, the opposite direction of immediate sign extension. It also sign- or zero-extends byte/halfword load data back to 32 bits. Each access runs a req/ack handshake with a variable-latency data memory, and the unit stalls the pipeline until the access completes.

## Interface
- TIMEOUT, default 0: max cycles to wait for mem_ack_i after mem_req_o rises; 0 = wait forever.
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous reset, active-low
- req_i  in  1  MEM stage holds a load/store this cycle
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- unsigned_i  in  1  load zero-extends when 1, sign-extends when 0
- addr_i  in  32  byte address
- wdata_i  in  32  store data (low bits used for byte/half)
- rdata_o  out  32  extended load result, valid while done_o
- done_o  out  1  one-cycle completion pulse
- stall_o  out  1  pipeline hold request
- err_o  out  1  error pulse, coincident with done_o
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  32  word address, {addr_i[31:2],2'b00}
- mem_be_o  out  4  byte enables, bit n = byte lane n (little-endian)
- mem_wdata_o  out  32  lane-replicated store data
- mem_ack_i  in  1  memory accepted write / returns read data this cycle
- mem_rdata_i  in  32  read data, valid with mem_ack_i

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE: when req_i=1, latch request, drive mem_* and go to WAIT. Otherwise hold.
- WAIT: mem_req_o=1. mem_addr_o/mem_be_o/mem_we_o/mem_wdata_o stay stable until ack.
  - mem_ack_i=1 -> capture result, go to DONE.
  - Timeout count reached (TIMEOUT>0) -> go to DONE with err_o=1, rdata_o=0.
- DONE: done_o=1, mem_req_o=0, then unconditionally go to IDLE. A req_i seen in DONE is not accepted; it is accepted in the following IDLE.
- stall_o = req_i & (state != DONE), combinational. All other outputs are registered.
- Store lanes:
  - byte: be = 4'b0001 << addr[1:0], wdata = {4{wdata_i[7:0]}}
  - half: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata_i[15:0]}}
  - word: be = 4'b1111, wdata = wdata_i
- Load extract:
  - byte lane addr[1:0]: bits [31:8] = unsigned_i ? 0 : bit 7
  - half lane addr[1]: bits [31:16] = unsigned_i ? 0 : bit 15
  - word: passed through unchanged
- Stores return rdata_o=0. mem_be_o is driven for loads too.
- req_i dropping mid-access (flush) is ignored; the access completes normally.
- mem_ack_i is ignored outside WAIT.
- Reset: rst_i=0 at an edge -> IDLE, counter 0, all registered outputs 0. This abandons any in-flight request; the memory must tolerate mem_req_o dropping without ack.

## Timing
- Request in IDLE at edge N -> mem_req_o high from N+1.
- Ack sampled at edge M -> mem_req_o low and done_o/rdata_o/err_o valid from M+1 for exactly one cycle. stall_o low in that same cycle.
- Minimum access is 3 cycles (IDLE, WAIT with immediate ack, DONE). Back-to-back accesses issue one every 3 cycles minimum.
- Timeout: err_o fires when WAIT has lasted TIMEOUT cycles without ack.

## Configuration
- MISALIGN_CHECK_EN defined: a misaligned access goes IDLE -> DONE directly, with no mem_req_o, err_o=1 and rdata_o=0.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
- Not defined: misaligned low address bits are ignored (half uses addr[1] only; word always aligned). err_o then signals timeout only.

## Test plan
- Signed byte load, addr 0x103, mem_rdata_i=0x80FF_1234, ack after 2 wait cycles -> rdata_o=0xFFFF_FF80, done_o 1 cycle, stall_o high 3 cycles then low.
- Unsigned half load, addr 0x102, rdata 0x8001_7FFF -> rdata_o=0x0000_8001. Signed half load at addr 0x100 -> 0x0000_7FFF.
- Byte store, addr 0x41, wdata_i=0x1234_56AB -> mem_be_o=4'b0010, mem_wdata_o=0xABAB_ABAB, mem_we_o=1, held stable until ack.
- TIMEOUT=4, never ack -> mem_req_o high 4 cycles, then done_o=1, err_o=1, rdata_o=0.
- With MISALIGN_CHECK_EN, word load at addr 0x2 -> no mem_req_o, done_o=err_o=1 one cycle after req_i. Without the macro -> access issued with mem_addr_o=0x0, mem_be_o=4'b1111.
- rst_i low during WAIT -> next cycle mem_req_o=0, done_o=0, state IDLE. A later ack is ignored.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if -- data-memory bus between the MEM-stage load/store
// unit and a variable-latency data memory.
//
// Signals (named from the load/store unit's point of view):
//   mem_req_o    unit -> mem  request, held high until mem_ack_i
//   mem_we_o     unit -> mem  1 = write, 0 = read
//   mem_addr_o   unit -> mem  word-aligned byte address
//   mem_be_o     unit -> mem  byte enables, bit n = byte lane n
//   mem_wdata_o  unit -> mem  lane-replicated write data
//   mem_ack_i    mem -> unit  write accepted / read data valid this cycle
//   mem_rdata_i  mem -> unit  read data, valid with mem_ack_i
//
// Modports: master = load/store unit, slave = memory.
interface mem_access_unit_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_be_o,
    output mem_wdata_o,
    input  mem_ack_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_be_o,
    input  mem_wdata_o,
    output mem_ack_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM-stage load/store datapath.
//
// Places store data on the correct byte lanes of the data memory, extracts
// and sign/zero-extends byte/halfword load data, and runs a req/ack
// handshake with a variable-latency memory while stalling the pipeline.
//
// Parameters:
//   TIMEOUT  max WAIT cycles without mem_ack_i before giving up with err_o
//            (0 = wait forever)
//
// Optional feature macro:
//   MISALIGN_CHECK_EN  when defined, misaligned half/word accesses complete
//                      immediately with err_o=1 and never reach memory.
//                      When undefined, the low address bits a half/word
//                      access does not need are simply ignored.
//
// Ports:
//   clk_i       clock, all state on the rising edge
//   rst_i       synchronous reset, active low
//   req_i       MEM stage holds a load/store this cycle
//   we_i        1 = store, 0 = load
//   size_i      00 byte, 01 half, 10/11 word
//   unsigned_i  load zero-extends when 1, sign-extends when 0
//   addr_i      byte address
//   wdata_i     store data (low bits used for byte/half)
//   rdata_o     extended load result, valid while done_o
//   done_o      one-cycle completion pulse
//   stall_o     pipeline hold request (combinational)
//   err_o       timeout / misalignment error, coincident with done_o
//   mem         data-memory bus (master side)
module mem_access_unit #(
  parameter int TIMEOUT = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [1:0]               size_i,
  input  logic                     unsigned_i,
  input  logic [31:0]              addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o,
  output logic                     done_o,
  output logic                     stall_o,
  output logic                     err_o,
  mem_access_unit_if.master        mem
);

  // Counter only needs to reach TIMEOUT-1; keep at least one bit.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  // Request attributes needed after issue to shape the load result.
  logic [1:0]    size_reg, size_next;
  logic          unsigned_reg, unsigned_next;
  logic [1:0]    lane_reg, lane_next;

  // Registered memory-side outputs.
  logic          mem_req_reg, mem_req_next;
  logic          mem_we_reg, mem_we_next;
  logic [31:0]   mem_addr_reg, mem_addr_next;
  logic [3:0]    mem_be_reg, mem_be_next;
  logic [31:0]   mem_wdata_reg, mem_wdata_next;

  // Registered pipeline-side outputs.
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic [31:0]   rdata_reg, rdata_next;

  logic          misaligned;
  logic          timeout_hit;

  // ------------------------------------------------------------------
  // Lane helpers
  // ------------------------------------------------------------------
  function automatic logic [3:0] store_be(input logic [1:0] size,
                                          input logic [1:0] lane);
    case (size)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0]  size,
                                             input logic [31:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                               input logic        uns,
                                               input logic [1:0]  lane,
                                               input logic [31:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      default: b = raw[31:24];
    endcase
    h = lane[1] ? raw[31:16] : raw[15:0];
    case (size)
      2'b00:   return {{24{b[7] & ~uns}}, b};
      2'b01:   return {{16{h[15] & ~uns}}, h};
      default: return raw;
    endcase
  endfunction

`ifdef MISALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lane);
    // size 11 is handled as a word access
    return ((size == 2'b01) && lane[0]) ||
           (size[1] && (lane != 2'b00));
  endfunction

  assign misaligned = is_misaligned(size_i, addr_i[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  // Last permitted WAIT cycle reached without ack (never when TIMEOUT=0).
  assign timeout_hit = (TIMEOUT > 0) && (cnt_reg == CW'(TIMEOUT - 1));

  // ------------------------------------------------------------------
  // Next-state / next-output logic
  // ------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    size_next      = size_reg;
    unsigned_next  = unsigned_reg;
    lane_next      = lane_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_be_next    = mem_be_reg;
    mem_wdata_next = mem_wdata_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    rdata_next     = 32'h0;

    case (state_reg)
      IDLE: begin
        if (req_i) begin
          if (misaligned) begin
            // Rejected without touching memory.
            state_next   = DONE;
            mem_req_next = 1'b0;
            done_next    = 1'b1;
            err_next     = 1'b1;
          end else begin
            state_next     = WAIT;
            cnt_next       = '0;
            size_next      = size_i;
            unsigned_next  = unsigned_i;
            lane_next      = addr_i[1:0];
            mem_req_next   = 1'b1;
            mem_we_next    = we_i;
            mem_addr_next  = {addr_i[31:2], 2'b00};
            mem_be_next    = store_be(size_i, addr_i[1:0]);
            mem_wdata_next = store_data(size_i, wdata_i);
          end
        end
      end

      WAIT: begin
        // Bus outputs hold their issued values; req_i is deliberately
        // not looked at here so a flush cannot abandon the access.
        if (mem.mem_ack_i) begin
          state_next   = DONE;
          mem_req_next = 1'b0;
          done_next    = 1'b1;
          rdata_next   = mem_we_reg ? 32'h0 :
                         load_extract(size_reg, unsigned_reg, lane_reg,
                                      mem.mem_rdata_i);
        end else if (timeout_hit) begin
          state_next   = DONE;
          mem_req_next = 1'b0;
          done_next    = 1'b1;
          err_next     = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      DONE: begin
        // A request seen here waits for the next IDLE cycle.
        state_next = IDLE;
      end

      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // State and output registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      size_reg      <= 2'b00;
      unsigned_reg  <= 1'b0;
      lane_reg      <= 2'b00;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 32'h0;
      mem_be_reg    <= 4'h0;
      mem_wdata_reg <= 32'h0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      rdata_reg     <= 32'h0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      size_reg      <= size_next;
      unsigned_reg  <= unsigned_next;
      lane_reg      <= lane_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_be_reg    <= mem_be_next;
      mem_wdata_reg <= mem_wdata_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      rdata_reg     <= rdata_next;
    end
  end

  // Stall drops in DONE so the pipeline advances in the completion cycle.
  assign stall_o         = req_i & (state_reg != DONE);

  assign done_o          = done_reg;
  assign err_o           = err_reg;
  assign rdata_o         = rdata_reg;
  assign mem.mem_req_o   = mem_req_reg;
  assign mem.mem_we_o    = mem_we_reg;
  assign mem.mem_addr_o  = mem_addr_reg;
  assign mem.mem_be_o    = mem_be_reg;
  assign mem.mem_wdata_o = mem_wdata_reg;

endmodule
